// File: rtl/fetch_sequencer_rv32i.sv
// Instruction-fetch sequencer: issues in-order word fetches, queues returned
// instructions with their PCs, and discards in-flight responses on redirect.
module fetch_sequencer_rv32i #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth  = CntW'(QUEUE_DEPTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     data_q [QUEUE_DEPTH];
  logic [31:0]     pc_q   [QUEUE_DEPTH];

  logic            redirect, accept, push, pop;
  logic [CntW-1:0] inflight;
  logic [31:0]     redirect_aligned;

  assign redirect         = redirect_valid && (state_q != StBoot);
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // Queue slots and in-flight requests share one credit pool, so the queue cannot overflow.
  assign imem_req_valid = (state_q == StRun) && ((outstanding_q + count_q) < Depth);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign inflight = outstanding_q + CntW'(accept) - CntW'(imem_rsp_valid);
  assign push     = imem_rsp_valid && !redirect && (drop_cnt_q == '0);
  assign pop      = inst_valid && inst_ready && !redirect;

  assign inst_valid = (count_q != '0);
  assign inst_out   = data_q[rd_ptr_q];
  assign inst_pc    = pc_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = inflight;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q + CntW'(push) - CntW'(pop);

    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntOne;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
      rsp_pc_d = rsp_pc_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrOne;

    // Everything still in flight after this cycle belongs to the old stream,
    // including a request accepted in the redirect cycle itself.
    if (redirect) begin
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      drop_cnt_d = inflight;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (redirect && (drop_cnt_d != '0)) state_d = StFlush;
      StFlush: if (drop_cnt_d == '0) state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        data_q[wr_ptr_q] <= imem_rsp_data;
        pc_q[wr_ptr_q]   <= rsp_pc_q;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && (count_q == Depth)));

endmodule

// File: tb/tb_fetch_sequencer_rv32i.sv
// Directed bench for fetch_sequencer_rv32i with an in-order instruction memory
// model (data = ~addr) whose responses can be held back.
module tb_fetch_sequencer_rv32i;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  logic        mem_hold = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] acc[$];

  int checks = 0;
  int failures = 0;

  fetch_sequencer_rv32i #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  // Memory: records accepted addresses, answers in order one cycle later unless held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      acc.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back(imem_req_addr);
        acc.push_back(imem_req_addr);
      end
      if (!mem_hold && pend.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= ~pend.pop_front();
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ir, input logic mr, input logic hd);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = ir;
    imem_req_ready = mr;
    mem_hold       = hd;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid got=%0h exp=0", imem_req_valid);
    end
    checks++;
    if (imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL reset_req_addr got=%0h exp=0", imem_req_addr);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_inst got valid=%0h out=%0h pc=%0h exp 0/0/0",
               inst_valid, inst_out, inst_pc);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ep;
    int nobs;
    do_reset(1'b1, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL stream_early_valid got=%0h exp=0", inst_valid);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1) begin
      failures++; $display("FAIL stream_first_valid got=%0h exp=1", inst_valid);
    end
    ep = 32'h0;
    nobs = 0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) begin
        checks++;
        if (inst_pc !== ep || inst_out !== ~ep) begin
          failures++;
          $display("FAIL stream_head got pc=%0h out=%0h exp pc=%0h out=%0h",
                   inst_pc, inst_out, ep, ~ep);
        end
        ep = ep + 32'd4;
        nobs++;
      end
      tick();
    end
    checks++;
    if (nobs < 10) begin
      failures++; $display("FAIL stream_count got=%0d exp>=10", nobs);
    end
    for (int i = 0; i < acc.size(); i++) begin
      checks++;
      if (acc[i] !== 32'(4 * i)) begin
        failures++; $display("FAIL stream_addr[%0d] got=%0h exp=%0h", i, acc[i], 4 * i);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (acc.size() !== 2 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_credit got accepted=%0d req_valid=%0h exp 2/0", acc.size(), imem_req_valid);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== 32'hffff_ffff) begin
      failures++;
      $display("FAIL bp_head got valid=%0h pc=%0h out=%0h exp 1/0/ffffffff",
               inst_valid, inst_pc, inst_out);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (inst_pc !== 32'h4 || inst_out !== ~32'h4) begin
      failures++; $display("FAIL bp_second got pc=%0h out=%0h exp pc=4", inst_pc, inst_out);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
      failures++;
      $display("FAIL bp_resume got valid=%0h addr=%0h exp 1/8", imem_req_valid, imem_req_addr);
    end
    tick();
    checks++;
    if (acc.size() !== 3 || acc[2] !== 32'h8) begin
      failures++; $display("FAIL bp_accept8 got accepted=%0d exp 3 with addr 8", acc.size());
    end
  endtask

  task automatic test_redirect_flush();
    int n;
    logic leak;
    do_reset(1'b1, 1'b1, 1'b0);
    n = 0;
    while (acc.size() < 2 && n < 10) begin tick(); n++; end
    mem_hold = 1'b1;
    n = 0;
    while (!(pend.size() == 2 && !inst_valid) && n < 20) begin tick(); n++; end
    checks++;
    if (acc.size() !== 4 || acc[2] !== 32'h8 || acc[3] !== 32'hc || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_setup got accepted=%0d req_valid=%0h exp 4 ending 8,c and 0",
               acc.size(), imem_req_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (dut.drop_cnt_q !== 2) begin
      failures++; $display("FAIL flush_drop_cnt got=%0d exp=2", dut.drop_cnt_q);
    end
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_quiet got req=%0h inst=%0h exp 0/0", imem_req_valid, inst_valid);
    end
    mem_hold = 1'b0;
    leak = 1'b0;
    n = 0;
    while (!imem_req_valid && n < 10) begin
      tick();
      if (inst_valid) leak = 1'b1;
      n++;
    end
    checks++;
    if (leak !== 1'b0) begin
      failures++; $display("FAIL flush_discard got leak=%0h exp=0", leak);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL flush_restart got valid=%0h addr=%0h exp 1/100", imem_req_valid, imem_req_addr);
    end
    n = 0;
    while (!inst_valid && n < 10) begin tick(); n++; end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_out !== ~32'h100) begin
      failures++;
      $display("FAIL flush_first_inst got valid=%0h pc=%0h out=%0h exp 1/100/fffffeff",
               inst_valid, inst_pc, inst_out);
    end
  endtask

  task automatic test_redirect_collide();
    int n;
    do_reset(1'b1, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (dut.outstanding_q !== 1 || imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL collide_setup got out=%0d rsp=%0h req=%0h exp 1/1/1",
               dut.outstanding_q, imem_rsp_valid, imem_req_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (dut.drop_cnt_q !== 1) begin
      failures++; $display("FAIL collide_drop_cnt got=%0d exp=1", dut.drop_cnt_q);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL collide_no_enqueue got=%0h exp=0", inst_valid);
    end
    n = 0;
    while (!imem_req_valid && n < 10) begin tick(); n++; end
    checks++;
    if (imem_req_addr !== 32'h200) begin
      failures++; $display("FAIL collide_addr got=%0h exp=200", imem_req_addr);
    end
    n = 0;
    while (!inst_valid && n < 10) begin tick(); n++; end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin
      failures++; $display("FAIL collide_first_inst got valid=%0h pc=%0h exp 1/200", inst_valid, inst_pc);
    end
  endtask

  task automatic test_redirect_idle();
    int n;
    do_reset(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL idle_setup got valid=%0h addr=%0h exp 1/0", imem_req_valid, imem_req_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL idle_redirect got valid=%0h addr=%0h exp 1/100", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    n = 0;
    while (!inst_valid && n < 10) begin tick(); n++; end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
      failures++; $display("FAIL idle_first_inst got valid=%0h pc=%0h exp 1/100", inst_valid, inst_pc);
    end
  endtask

  task automatic test_reset_in_flush();
    int n;
    do_reset(1'b1, 1'b1, 1'b1);
    tick();
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (dut.drop_cnt_q !== 1 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstflush_setup got drop=%0d req=%0h exp 1/0", dut.drop_cnt_q, imem_req_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL rstflush_req got valid=%0h addr=%0h exp 0/0", imem_req_valid, imem_req_addr);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0 || dut.drop_cnt_q !== 0) begin
      failures++;
      $display("FAIL rstflush_state got valid=%0h out=%0h pc=%0h drop=%0d exp all 0",
               inst_valid, inst_out, inst_pc, dut.drop_cnt_q);
    end
    @(negedge clk);
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    rst            = 1'b0;
    n = 0;
    while (!inst_valid && n < 10) begin tick(); n++; end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || acc.size() == 0 || acc[0] !== 32'h0) begin
      failures++;
      $display("FAIL rstflush_restart got valid=%0h pc=%0h accepted=%0d exp 1/0 from addr 0",
               inst_valid, inst_pc, acc.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collide();
    test_redirect_idle();
    test_reset_in_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
